vpifo_task_scheduler: RTL and testbench

Admission scheduler between per-tree task requesters and the LEVEL ring-connected RPU entry ports of the virtualized SRAM PIFO tree. Each tree's root lives in RPU (tree_id mod LEVEL). The block round-robin arbitrates, per RPU, among the trees rooted there, and withholds injection when that RPU is claimed by a propagating ring operation. It also enforces a per-tree pop cooldown so that a tree is not re-entered before its previous pop has finished its read-modify-write walk.

---
 rtl/vpifo_pkg.sv | 30 +++
 rtl/vpifo_task_scheduler_rr_arbiter.sv | 37 +++
 rtl/vpifo_task_scheduler.sv | 128 ++++++++++++
 tb/tb_vpifo_task_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vpifo_pkg.sv
// Shared sizing helpers and tree-to-slot mapping for the vPIFO task scheduler.
package vpifo_pkg;

  // Index widths collapse to 1 bit when only one value exists.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned data_width(input int unsigned ptw, input int unsigned mtw);
    return ptw + mtw;
  endfunction

  function automatic int unsigned cool_width(input int unsigned cooldown);
    return clog2_min1(cooldown + 1);
  endfunction

  function automatic int unsigned slot_of_tree(input int unsigned t, input int unsigned level);
    return t % level;
  endfunction

  function automatic int unsigned idx_of_tree(input int unsigned t, input int unsigned level);
    return t / level;
  endfunction

  function automatic int unsigned tree_of(input int unsigned k, input int unsigned r,
                                          input int unsigned level);
    return k * level + r;
  endfunction

endpackage

// File: rtl/vpifo_task_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after ptr_i wins.
module rr_arbiter
  import vpifo_pkg::*;
#(
  parameter int unsigned N  = 2,
  localparam int unsigned PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic [PW-1:0] ptr_next_o,
  output logic          valid_o
);

  int unsigned k;
  logic        found;

  always_comb begin
    gnt_o      = '0;
    gnt_idx_o  = '0;
    ptr_next_o = ptr_i;
    found      = 1'b0;
    k          = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr_i) + i) % N;
      if (!found && req_i[k]) begin
        found      = 1'b1;
        gnt_o[k]   = 1'b1;
        gnt_idx_o  = PW'(k);
        ptr_next_o = PW'((k + 1) % N);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/vpifo_task_scheduler.sv
// Admission scheduler: per-RPU round-robin over the trees rooted there, with ring-busy
// back-off and a per-tree pop cooldown.
module vpifo_task_scheduler
  import vpifo_pkg::*;
#(
  parameter int unsigned PTW      = 16,
  parameter int unsigned MTW      = 0,
  parameter int unsigned LEVEL    = 4,
  parameter int unsigned TREE_NUM = 8,
  parameter int unsigned COOLDOWN = LEVEL,
  localparam int unsigned DW = data_width(PTW, MTW),
  localparam int unsigned TW = clog2_min1(TREE_NUM)
) (
  input  logic                          i_clk,
  input  logic                          i_arst_n,
  input  logic [TREE_NUM-1:0]           i_req_valid,
  input  logic [TREE_NUM-1:0]           i_req_is_push,
  input  logic [TREE_NUM-1:0][DW-1:0]   i_req_data,
  output logic [TREE_NUM-1:0]           o_req_ready,
  input  logic [LEVEL-1:0]              i_slot_busy,
  output logic [LEVEL-1:0]              o_rpu_push,
  output logic [LEVEL-1:0]              o_rpu_pop,
  output logic [LEVEL-1:0][TW-1:0]      o_rpu_tree_id,
  output logic [LEVEL-1:0][DW-1:0]      o_rpu_push_data,
  output logic [TREE_NUM-1:0]           o_cooling
);

  localparam int unsigned K  = TREE_NUM / LEVEL;
  localparam int unsigned PW = clog2_min1(K);
  localparam int unsigned CW = cool_width(COOLDOWN);

  logic [LEVEL-1:0][PW-1:0]    ptr_q, ptr_d;
  logic [TREE_NUM-1:0][CW-1:0] cool_q, cool_d;
  logic [LEVEL-1:0]            push_q, push_d, pop_q, pop_d;
  logic [LEVEL-1:0][TW-1:0]    id_q, id_d;
  logic [LEVEL-1:0][DW-1:0]    data_q, data_d;

  logic [K-1:0]  slot_req [LEVEL];
  logic [K-1:0]  slot_gnt [LEVEL];
  logic [PW-1:0] slot_idx [LEVEL];
  logic [PW-1:0] slot_nxt [LEVEL];
  logic          slot_any [LEVEL];

  int unsigned t_req, t_gnt;

  // Reset gates eligibility so ready stays low while i_arst_n is asserted.
  always_comb begin
    t_req = 0;
    for (int unsigned r = 0; r < LEVEL; r++) begin
      slot_req[r] = '0;
      for (int unsigned k = 0; k < K; k++) begin
        t_req = tree_of(k, r, LEVEL);
        slot_req[r][k] = i_arst_n & i_req_valid[t_req] & (cool_q[t_req] == '0) &
                         ~i_slot_busy[r];
      end
    end
  end

  for (genvar r = 0; r < LEVEL; r++) begin : g_slot
    rr_arbiter #(
      .N (K)
    ) u_arb (
      .req_i      (slot_req[r]),
      .ptr_i      (ptr_q[r]),
      .gnt_o      (slot_gnt[r]),
      .gnt_idx_o  (slot_idx[r]),
      .ptr_next_o (slot_nxt[r]),
      .valid_o    (slot_any[r])
    );
  end

  always_comb begin
    o_req_ready = '0;
    ptr_d       = ptr_q;
    push_d      = '0;
    pop_d       = '0;
    id_d        = '0;
    data_d      = '1;
    t_gnt       = 0;
    for (int unsigned r = 0; r < LEVEL; r++) begin
      if (slot_any[r]) begin
        t_gnt              = tree_of(32'(slot_idx[r]), r, LEVEL);
        o_req_ready[t_gnt] = 1'b1;
        ptr_d[r]           = slot_nxt[r];
        id_d[r]            = TW'(t_gnt);
        push_d[r]          = i_req_is_push[t_gnt];
        pop_d[r]           = ~i_req_is_push[t_gnt];
        if (i_req_is_push[t_gnt]) data_d[r] = i_req_data[t_gnt];
      end
    end
  end

  always_comb begin
    cool_d = cool_q;
    for (int unsigned t = 0; t < TREE_NUM; t++) begin
      if (o_req_ready[t] && !i_req_is_push[t]) begin
        cool_d[t] = CW'(COOLDOWN);
      end else if (cool_q[t] != '0) begin
        cool_d[t] = cool_q[t] - 1'b1;
      end
      o_cooling[t] = (cool_q[t] != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ptr_q  <= '0;
      cool_q <= '0;
      push_q <= '0;
      pop_q  <= '0;
      id_q   <= '0;
      data_q <= '1;
    end else begin
      ptr_q  <= ptr_d;
      cool_q <= cool_d;
      push_q <= push_d;
      pop_q  <= pop_d;
      id_q   <= id_d;
      data_q <= data_d;
    end
  end

  assign o_rpu_push      = push_q;
  assign o_rpu_pop       = pop_q;
  assign o_rpu_tree_id   = id_q;
  assign o_rpu_push_data = data_q;

endmodule

// File: tb/tb_vpifo_task_scheduler.sv
// Directed and random checks of vpifo_task_scheduler against a queue-free behavioural model.
module tb_vpifo_task_scheduler;

  localparam int unsigned PTW = 16, MTW = 0, LEVEL = 4, TREE_NUM = 8, COOLDOWN = 4;
  localparam int unsigned DW = PTW + MTW, TW = 3, K = TREE_NUM / LEVEL;

  logic                        i_clk = 1'b0;
  logic                        i_arst_n;
  logic [TREE_NUM-1:0]         i_req_valid;
  logic [TREE_NUM-1:0]         i_req_is_push;
  logic [TREE_NUM-1:0][DW-1:0] i_req_data;
  logic [TREE_NUM-1:0]         o_req_ready;
  logic [LEVEL-1:0]            i_slot_busy;
  logic [LEVEL-1:0]            o_rpu_push;
  logic [LEVEL-1:0]            o_rpu_pop;
  logic [LEVEL-1:0][TW-1:0]    o_rpu_tree_id;
  logic [LEVEL-1:0][DW-1:0]    o_rpu_push_data;
  logic [TREE_NUM-1:0]         o_cooling;

  vpifo_task_scheduler #(
    .PTW      (PTW),
    .MTW      (MTW),
    .LEVEL    (LEVEL),
    .TREE_NUM (TREE_NUM),
    .COOLDOWN (COOLDOWN)
  ) dut (
    .i_clk           (i_clk),
    .i_arst_n        (i_arst_n),
    .i_req_valid     (i_req_valid),
    .i_req_is_push   (i_req_is_push),
    .i_req_data      (i_req_data),
    .o_req_ready     (o_req_ready),
    .i_slot_busy     (i_slot_busy),
    .o_rpu_push      (o_rpu_push),
    .o_rpu_pop       (o_rpu_pop),
    .o_rpu_tree_id   (o_rpu_tree_id),
    .o_rpu_push_data (o_rpu_push_data),
    .o_cooling       (o_cooling)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: round-robin pointer per slot and remaining cooldown per tree.
  int m_ptr [LEVEL];
  int n_ptr [LEVEL];
  int m_cool[TREE_NUM];
  int n_cool[TREE_NUM];
  logic [TREE_NUM-1:0]      e_ready;
  logic [LEVEL-1:0]         e_push, e_pop;
  logic [LEVEL-1:0][TW-1:0] e_id;
  logic [LEVEL-1:0][DW-1:0] e_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit found;
    int k, t;
    e_ready = '0; e_push = '0; e_pop = '0; e_id = '0; e_data = '1;
    n_ptr = m_ptr;
    for (int r = 0; r < LEVEL; r++) begin
      found = 0;
      for (int i = 0; i < K; i++) begin
        k = (m_ptr[r] + i) % K;
        t = k * LEVEL + r;
        if (!found && !i_slot_busy[r] && i_req_valid[t] && m_cool[t] == 0) begin
          found      = 1;
          e_ready[t] = 1'b1;
          n_ptr[r]   = (k + 1) % K;
          e_id[r]    = 3'(t);
          if (i_req_is_push[t]) begin
            e_push[r] = 1'b1;
            e_data[r] = i_req_data[t];
          end else begin
            e_pop[r] = 1'b1;
          end
        end
      end
    end
    for (int t2 = 0; t2 < TREE_NUM; t2++) begin
      if (e_ready[t2] && !i_req_is_push[t2]) n_cool[t2] = COOLDOWN;
      else n_cool[t2] = (m_cool[t2] > 0) ? m_cool[t2] - 1 : 0;
    end
  endtask

  // Called at posedge+1 with inputs set; returns at the following posedge+1.
  task automatic step();
    logic [TREE_NUM-1:0] e_cool;
    #1;
    model_eval();
    check("ready", o_req_ready, e_ready);
    @(posedge i_clk);
    #1;
    m_ptr  = n_ptr;
    m_cool = n_cool;
    for (int t = 0; t < TREE_NUM; t++) e_cool[t] = (m_cool[t] != 0);
    check("rpu_push", o_rpu_push, e_push);
    check("rpu_pop", o_rpu_pop, e_pop);
    check("rpu_tree_id", o_rpu_tree_id, e_id);
    check("rpu_push_data", o_rpu_push_data, e_data);
    check("cooling", o_cooling, e_cool);
  endtask

  task automatic apply_reset();
    i_arst_n = 1'b0;
    #1;
    check("rst_push", o_rpu_push, 4'h0);
    check("rst_pop", o_rpu_pop, 4'h0);
    check("rst_id", o_rpu_tree_id, 12'h000);
    check("rst_data", o_rpu_push_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_cooling", o_cooling, 8'h00);
    check("rst_ready", o_req_ready, 8'h00);
    for (int r = 0; r < LEVEL; r++) m_ptr[r] = 0;
    for (int t = 0; t < TREE_NUM; t++) m_cool[t] = 0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_arst_n = 1'b1;
  endtask

  task automatic clear_inputs();
    i_req_valid = '0; i_req_is_push = '0; i_slot_busy = '0;
  endtask

  int cnt_pop, cnt_cool;
  logic [LEVEL-1:0][TW-1:0] prev_id;

  initial begin
    i_arst_n = 1'b0;
    clear_inputs();
    i_req_data = '0;
    @(posedge i_clk);
    #1;
    apply_reset();

    // Idle after reset.
    step();
    check("idle_data", o_rpu_push_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Trees 1 and 5 share slot 1 and must alternate.
    i_req_valid[1] = 1; i_req_is_push[1] = 1; i_req_data[1] = 16'hA001;
    i_req_valid[5] = 1; i_req_is_push[5] = 1; i_req_data[5] = 16'hA005;
    for (int i = 0; i < 4; i++) begin
      step();
      check("alt_id", o_rpu_tree_id[1], (i % 2) ? 3'd5 : 3'd1);
      check("alt_data", o_rpu_push_data[1], (i % 2) ? 16'hA005 : 16'hA001);
    end
    clear_inputs();
    step();

    // Tree 2 pops continuously: grants every COOLDOWN+1 cycles.
    i_req_valid[2] = 1;
    cnt_pop = 0; cnt_cool = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      cnt_pop  += int'(o_rpu_pop[2]);
      cnt_cool += int'(o_cooling[2]);
    end
    check("pop2_grants", cnt_pop, 3);
    check("pop2_cool_cycles", cnt_cool, 9);
    clear_inputs();
    repeat (5) step();

    // Busy slot 3 holds off tree 3.
    i_req_valid[3] = 1; i_req_is_push[3] = 1; i_req_data[3] = 16'h3333; i_slot_busy[3] = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_no_push", o_rpu_push[3], 1'b0);
    end
    i_slot_busy[3] = 0;
    step();
    check("busy_release_push", o_rpu_push[3], 1'b1);
    check("busy_release_id", o_rpu_tree_id[3], 3'd3);
    clear_inputs();
    step();

    // All trees valid: one grant per slot, then the sibling tree in each slot.
    i_req_valid = '1; i_req_is_push = '1;
    for (int t = 0; t < TREE_NUM; t++) i_req_data[t] = 16'($urandom);
    step();
    check("all_push_1", o_rpu_push, 4'hF);
    prev_id = o_rpu_tree_id;
    step();
    check("all_push_2", o_rpu_push, 4'hF);
    check("all_sibling", o_rpu_tree_id, prev_id ^ 12'h924);
    clear_inputs();
    step();

    // Reset while tree 6 is cooling; it must be grantable right after release.
    i_req_valid[6] = 1;
    step();
    i_req_valid[6] = 0;
    step();
    step();
    apply_reset();
    i_req_valid[6] = 1;
    step();
    check("rst_regrant_pop", o_rpu_pop[2], 1'b1);
    check("rst_regrant_id", o_rpu_tree_id[2], 3'd6);
    clear_inputs();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      i_req_valid   = 8'($urandom);
      i_req_is_push = 8'($urandom);
      for (int t = 0; t < TREE_NUM; t++) i_req_data[t] = 16'($urandom);
      i_slot_busy   = 4'($urandom) & 4'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
